vfreq_seq_ctrl: RTL and testbench
=================================

# vfreq_seq_ctrl

Sequencer for the variable-frequency divider: holds a small programmable table of (divide value, duration) entries and plays them in order, driving the divider's divide value and enable and counting the divider's output ticks to decide when to step. It sits between the configuration inputs and the divider core, so that frequency sweeps and tone patterns run without per-step host intervention. Optional looping, pause and abort are supported.

## Interface
- DEPTH, 8, number of table entries (power of two)
- DW, 8, divide-value width (matches divider compare width)
- CW, 8, per-entry duration width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- cfg_we  in  1  table write strobe
- cfg_addr  in  log2(DEPTH)  table entry index
- cfg_div  in  DW  divide value written to entry
- cfg_dur  in  CW  duration written to entry (entry lasts cfg_dur+1 ticks)
- seq_len  in  log2(DEPTH)+1  number of active entries, sampled at start
- loop_en  in  1  1 = wrap to entry 0 after last entry; sampled every step
- start  in  1  single-cycle start request
- pause  in  1  level; holds sequence while high
- stop  in  1  single-cycle abort
- div_tick  in  1  one-cycle pulse from divider, one per divided period
- div_val  out  DW  divide value presented to divider
- div_en  out  1  divider enable (divider clears its counter while low)
- step_idx  out  log2(DEPTH)  index of entry currently presented
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on natural completion

## Operation
- States: IDLE, RUN, PAUSE, DONE. All outputs registered.
- Table: DEPTH×(DW+CW) registers, cleared to 0 by reset. cfg_we writes at the clock edge in any state. A write to the entry currently running does not alter it (values latched on entry); it takes effect on the next load of that entry.
- IDLE: div_en=0, div_val=0, step_idx=0. On start with effective length L≠0: latch L, load entry 0 (div_val←div[0], tick_cnt←dur[0], step_idx←0), go RUN. L = min(seq_len, DEPTH). start with L=0 is ignored.
- RUN: div_en=1. On div_tick: if tick_cnt≠0, decrement; if tick_cnt==0, step:
  - step_idx<L-1: load entry step_idx+1, stay RUN.
  - step_idx==L-1, loop_en=1: load entry 0, stay RUN.
  - step_idx==L-1, loop_en=0: go DONE.
- Stepping reloads div_val, tick_cnt and step_idx in the same edge; div_en stays high across steps (no gap).
- pause high in RUN → PAUSE: div_en=0, tick_cnt, step_idx, div_val held; div_tick ignored. pause low → RUN; divider restarts the current entry's period from zero, remaining tick count preserved.
- DONE: div_en=0, done=1 for exactly one cycle, busy=1; next cycle IDLE, div_val and step_idx cleared.
- stop in RUN, PAUSE or DONE → IDLE next edge; no done pulse. Priority: stop > div_tick > pause. start while busy is ignored. Tick and pause in the same RUN cycle: the tick is counted and stepping occurs, then PAUSE.
- Arithmetic: tick_cnt is CW bits, down-counting, no wrap (never decremented below 0). Index wraps only through loop_en.

## Timing
- Reset (async, any time): state IDLE, div_val=0, div_en=0, step_idx=0, busy=0, done=0, tick_cnt=0, table cleared. Release is synchronous to clk.
- start sampled at edge N → div_en=1, div_val=div[0], busy=1 from cycle N+1.
- A final div_tick of an entry sampled at edge M → new div_val/step_idx visible at M+1; in the non-loop case done=1 and div_en=0 at M+1, busy=0 at M+2.
- Entry k lasts exactly dur[k]+1 div_ticks; a full non-looping sequence consumes Σ(dur[k]+1) ticks.
- pause/stop take effect on the output one cycle after they are sampled.

## Test plan
- Reset mid-RUN: assert rst_n low asynchronously → all outputs 0 immediately, table reads back as 0 and a subsequent start with L=1 runs div_val=0.
- Program div={10,20,30}, dur={0,1,2}, seq_len=3, loop_en=0, start → div_val 10 for 1 tick, 20 for 2 ticks, 30 for 3 ticks; done pulses once after the 6th tick; div_en drops the same cycle.
- Same table with loop_en=1 → after the 6th tick div_val=10, step_idx=0, no done; stop → IDLE next cycle, no done.
- Pause after 1 of 3 ticks on entry 2, hold 5 cycles with ticks driven → div_en=0, ticks ignored; release → exactly 2 more ticks before done.
- seq_len=0 with start → stays IDLE, busy=0; seq_len=12 with DEPTH=8 → plays 8 entries.
- cfg_we to the running entry during RUN → current div_val is unchanged; new value appears on the next loop pass; start pulsed while busy → no restart.

Source files
------------

// File: rtl/vfreq_seq_if.sv
// Host/divider-facing signal bundle of the variable-frequency sequencer.
// The master side is the host plus divider; the slave side is the sequencer.
interface vfreq_seq_if #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter int CW    = 8
);
  localparam int AW = $clog2(DEPTH);

  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_div;
  logic [CW-1:0] cfg_dur;
  logic [AW:0]   seq_len;
  logic          loop_en;
  logic          start;
  logic          pause;
  logic          stop;
  logic          div_tick;
  logic [DW-1:0] div_val;
  logic          div_en;
  logic [AW-1:0] step_idx;
  logic          busy;
  logic          done;

  modport master (
    output cfg_we, cfg_addr, cfg_div, cfg_dur, seq_len, loop_en,
           start, pause, stop, div_tick,
    input  div_val, div_en, step_idx, busy, done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_div, cfg_dur, seq_len, loop_en,
           start, pause, stop, div_tick,
    output div_val, div_en, step_idx, busy, done
  );
endinterface

// File: rtl/vfreq_seq_ctrl.sv
// Plays a table of (divide value, duration) entries into the divider.
// Each entry lasts dur+1 divider ticks; it supports looping, pause and abort.
module vfreq_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int DW    = 8,
  parameter int CW    = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  vfreq_seq_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] tbl_div [DEPTH];
  logic [CW-1:0] tbl_dur [DEPTH];
  logic [DW-1:0] div_val_q, div_val_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d, load_idx;
  logic [LW-1:0] len_q, len_d, eff_len;
  logic          div_en_q, busy_q, done_q;
  logic          load, at_last;

  // NOTE: table entries get a reset because the table must read back as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_div[i] <= '0;
        tbl_dur[i] <= '0;
      end
    end else if (bus.cfg_we) begin
      tbl_div[bus.cfg_addr] <= bus.cfg_div;
      tbl_dur[bus.cfg_addr] <= bus.cfg_dur;
    end
  end

  assign eff_len = (bus.seq_len > LW'(DEPTH)) ? LW'(DEPTH) : bus.seq_len;
  assign at_last = ({1'b0, idx_q} == len_q - LW'(1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
    state_d   = state_q;
    div_val_d = div_val_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    len_d     = len_q;
    load      = 1'b0;
    load_idx  = '0;
    case (state_q)
      IDLE: begin
        if (bus.start && eff_len != '0) begin
          len_d   = eff_len;
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          if (bus.div_tick) begin
            if (cnt_q != '0) begin
              cnt_d = cnt_q - CW'(1);
            end else if (!at_last) begin
              load     = 1'b1;
              load_idx = idx_q + AW'(1);
            end else if (bus.loop_en) begin
              load = 1'b1;
            end else begin
              state_d = DONE;
            end
          end
          // A tick in the same cycle is consumed before pausing.
          if (bus.pause && state_d == RUN) state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (bus.stop)        state_d = IDLE;
        else if (!bus.pause) state_d = RUN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (load) begin
      div_val_d = tbl_div[load_idx];
      cnt_d     = tbl_dur[load_idx];
      idx_d     = load_idx;
    end
    if (state_d == IDLE) begin
      div_val_d = '0;
      cnt_d     = '0;
      idx_d     = '0;
    end
  end

  // NOTE: non-blocking assignments so all registers update from pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      div_val_q <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      div_en_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_val_q <= div_val_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      div_en_q  <= (state_d == RUN);
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_d == DONE);
    end
  end

  assign bus.div_val  = div_val_q;
  assign bus.div_en   = div_en_q;
  assign bus.step_idx = idx_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_vfreq_seq_ctrl.sv
// Self-checking bench for vfreq_seq_ctrl: directed vector table, corner sequences,
// and randomized runs against a tick-queue reference model.
module tb_vfreq_seq_ctrl;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int CW    = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;

  vfreq_seq_if #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) bus ();

  vfreq_seq_ctrl #(.DEPTH(DEPTH), .DW(DW), .CW(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Packed outputs: {div_val, div_en, step_idx, busy, done}
  typedef struct packed {logic [7:0] d; logic [2:0] i;} slot_t;
  typedef struct {
    logic start, tick, pause, stop, loop_en;
    logic [3:0]  len;
    logic [13:0] exp;
  } vec_t;

  vec_t  vecs[$];
  slot_t q[$];
  slot_t last;
  bit    m_act, m_paused, m_done;
  logic [7:0] mdiv [DEPTH];
  logic [7:0] mdur [DEPTH];

  function automatic logic [13:0] pk(logic [7:0] v, logic en, logic [2:0] i, logic b, logic d);
    return {v, en, i, b, d};
  endfunction

  function automatic vec_t mk(logic s, logic t, logic p, logic st, logic lp,
                              logic [3:0] len, logic [13:0] e);
    vec_t v;
    v.start = s; v.tick = t; v.pause = p; v.stop = st; v.loop_en = lp;
    v.len = len; v.exp = e;
    return v;
  endfunction

  function automatic logic [13:0] outs();
    return {bus.div_val, bus.div_en, bus.step_idx, bus.busy, bus.done};
  endfunction

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got {val,en,idx,busy,done}=%h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic t, input logic p, input logic st);
    bus.start = s; bus.div_tick = t; bus.pause = p; bus.stop = st;
    cyc();
    bus.start = 1'b0; bus.div_tick = 1'b0; bus.stop = 1'b0;
  endtask

  task automatic cfg_write(input logic [2:0] a, input logic [7:0] d, input logic [7:0] u);
    bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_div = d; bus.cfg_dur = u;
    mdiv[a] = d; mdur[a] = u;
    cyc();
    bus.cfg_we = 1'b0;
  endtask

  // Reference: on start the whole play-out is expanded into one queue slot per tick.
  task automatic model_step(input logic s, input logic t, input logic p, input logic st,
                            input logic [3:0] len);
    int l;
    if (m_done) begin
      m_done = 0; m_act = 0;
    end else if (m_act) begin
      if (st) begin
        m_act = 0; m_paused = 0; q.delete();
      end else if (m_paused) begin
        if (!p) m_paused = 0;
      end else begin
        if (t) begin
          last = q.pop_front();
          if (q.size() == 0) m_done = 1;
        end
        if (!m_done && p) m_paused = 1;
      end
    end else if (s) begin
      l = (len > DEPTH) ? DEPTH : int'(len);
      if (l != 0) begin
        for (int k = 0; k < l; k++)
          for (int r = 0; r <= int'(mdur[k]); r++) q.push_back({mdiv[k], 3'(k)});
        m_act = 1;
      end
    end
  endtask

  function automatic logic [13:0] model_exp();
    if (m_done) return pk(last.d, 1'b0, last.i, 1'b1, 1'b1);
    if (m_act)  return pk(q[0].d, !m_paused, q[0].i, 1'b1, 1'b0);
    return '0;
  endfunction

  initial begin
    logic s, t, p, st;
    logic [3:0] len;
    bus.cfg_we = 0; bus.cfg_addr = 0; bus.cfg_div = 0; bus.cfg_dur = 0;
    bus.seq_len = 0; bus.loop_en = 0; bus.start = 0; bus.pause = 0;
    bus.stop = 0; bus.div_tick = 0;
    repeat (2) @(negedge clk);
    check("reset_outputs", outs(), '0);
    rst_n = 1'b1;
    cyc();
    check("idle_after_reset", outs(), '0);

    cfg_write(0, 8'd10, 8'd0);
    cfg_write(1, 8'd20, 8'd1);
    cfg_write(2, 8'd30, 8'd2);

    // Basic non-looping play-out: 1, 2, 3 ticks then done.
    vecs.push_back(mk(1,0,0,0,0,3, pk(10,1,0,1,0)));
    vecs.push_back(mk(0,1,0,0,0,3, pk(20,1,1,1,0)));
    vecs.push_back(mk(0,0,0,0,0,3, pk(20,1,1,1,0)));
    vecs.push_back(mk(0,1,0,0,0,3, pk(20,1,1,1,0)));
    vecs.push_back(mk(0,1,0,0,0,3, pk(30,1,2,1,0)));
    vecs.push_back(mk(0,1,0,0,0,3, pk(30,1,2,1,0)));
    vecs.push_back(mk(0,1,0,0,0,3, pk(30,1,2,1,0)));
    vecs.push_back(mk(0,1,0,0,0,3, pk(30,0,2,1,1)));
    vecs.push_back(mk(0,0,0,0,0,3, pk(0,0,0,0,0)));
    // Looping: wraps to entry 0 after 6 ticks, then stop.
    vecs.push_back(mk(1,0,0,0,1,3, pk(10,1,0,1,0)));
    vecs.push_back(mk(0,1,0,0,1,3, pk(20,1,1,1,0)));
    vecs.push_back(mk(0,1,0,0,1,3, pk(20,1,1,1,0)));
    vecs.push_back(mk(0,1,0,0,1,3, pk(30,1,2,1,0)));
    vecs.push_back(mk(0,1,0,0,1,3, pk(30,1,2,1,0)));
    vecs.push_back(mk(0,1,0,0,1,3, pk(30,1,2,1,0)));
    vecs.push_back(mk(0,1,0,0,1,3, pk(10,1,0,1,0)));
    vecs.push_back(mk(0,0,0,1,1,3, pk(0,0,0,0,0)));
    vecs.push_back(mk(0,0,0,0,1,3, pk(0,0,0,0,0)));
    // Pause after 1 of 3 ticks on entry 2; ticks ignored while paused.
    vecs.push_back(mk(1,0,0,0,0,3, pk(10,1,0,1,0)));
    vecs.push_back(mk(0,1,0,0,0,3, pk(20,1,1,1,0)));
    vecs.push_back(mk(0,1,0,0,0,3, pk(20,1,1,1,0)));
    vecs.push_back(mk(0,1,0,0,0,3, pk(30,1,2,1,0)));
    vecs.push_back(mk(0,1,0,0,0,3, pk(30,1,2,1,0)));
    vecs.push_back(mk(0,0,1,0,0,3, pk(30,0,2,1,0)));
    for (int k = 0; k < 4; k++) vecs.push_back(mk(0,1,1,0,0,3, pk(30,0,2,1,0)));
    vecs.push_back(mk(0,0,0,0,0,3, pk(30,1,2,1,0)));
    vecs.push_back(mk(0,1,0,0,0,3, pk(30,1,2,1,0)));
    vecs.push_back(mk(0,1,0,0,0,3, pk(30,0,2,1,1)));
    vecs.push_back(mk(0,0,0,0,0,3, pk(0,0,0,0,0)));
    // Zero length start is ignored.
    vecs.push_back(mk(1,0,0,0,0,0, pk(0,0,0,0,0)));
    vecs.push_back(mk(0,0,0,0,0,0, pk(0,0,0,0,0)));
    // Stop from PAUSE; tick+pause in one cycle; stop beats tick.
    vecs.push_back(mk(1,0,0,0,0,3, pk(10,1,0,1,0)));
    vecs.push_back(mk(0,0,1,0,0,3, pk(10,0,0,1,0)));
    vecs.push_back(mk(0,0,1,1,0,3, pk(0,0,0,0,0)));
    vecs.push_back(mk(0,0,0,0,0,3, pk(0,0,0,0,0)));
    vecs.push_back(mk(1,0,0,0,0,3, pk(10,1,0,1,0)));
    vecs.push_back(mk(0,1,1,0,0,3, pk(20,0,1,1,0)));
    vecs.push_back(mk(0,0,0,0,0,3, pk(20,1,1,1,0)));
    vecs.push_back(mk(0,1,0,1,0,3, pk(0,0,0,0,0)));

    for (int k = 0; k < vecs.size(); k++) begin
      bus.loop_en = vecs[k].loop_en;
      bus.seq_len = vecs[k].len;
      drive(vecs[k].start, vecs[k].tick, vecs[k].pause, vecs[k].stop);
      check($sformatf("vec%0d", k), outs(), vecs[k].exp);
    end

    // seq_len above DEPTH plays exactly DEPTH entries.
    for (int k = 0; k < DEPTH; k++) cfg_write(3'(k), 8'(k + 1), 8'd0);
    bus.seq_len = 4'd12; bus.loop_en = 0;
    drive(1, 0, 0, 0);
    check("len12_start", outs(), pk(1,1,0,1,0));
    for (int k = 1; k < DEPTH; k++) begin
      drive(0, 1, 0, 0);
      check($sformatf("len12_step%0d", k), outs(), pk(8'(k + 1), 1, 3'(k), 1, 0));
    end
    drive(0, 1, 0, 0);
    check("len12_done", outs(), pk(8,0,7,1,1));
    drive(0, 0, 0, 0);
    check("len12_idle", outs(), '0);

    // Write to running entry and start while busy.
    cfg_write(0, 8'd10, 8'd0);
    cfg_write(1, 8'd20, 8'd1);
    cfg_write(2, 8'd30, 8'd2);
    bus.seq_len = 4'd3; bus.loop_en = 1;
    drive(1, 0, 0, 0);
    check("wr_start", outs(), pk(10,1,0,1,0));
    cfg_write(0, 8'd99, 8'd0);
    check("wr_running_unchanged", outs(), pk(10,1,0,1,0));
    drive(0, 1, 0, 0);
    check("wr_step1", outs(), pk(20,1,1,1,0));
    drive(1, 0, 0, 0);
    check("start_while_busy", outs(), pk(20,1,1,1,0));
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    check("wr_step2", outs(), pk(30,1,2,1,0));
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    drive(0, 1, 0, 0);
    check("wr_new_value_on_loop", outs(), pk(99,1,0,1,0));
    drive(0, 0, 0, 1);
    check("wr_stop", outs(), '0);

    // Asynchronous reset mid-run clears outputs and table.
    bus.loop_en = 0;
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    check("pre_reset_run", outs(), pk(20,1,1,1,0));
    #2 rst_n = 1'b0;
    #1 check("async_reset", outs(), '0);
    @(negedge clk) rst_n = 1'b1;
    bus.seq_len = 4'd1;
    drive(1, 0, 0, 0);
    check("table_cleared", outs(), pk(0,1,0,1,0));
    drive(0, 1, 0, 0);
    check("table_cleared_done", outs(), pk(0,0,0,1,1));
    drive(0, 0, 0, 0);
    for (int k = 0; k < DEPTH; k++) begin mdiv[k] = 0; mdur[k] = 0; end

    // Randomized runs against the reference model.
    m_act = 0; m_paused = 0; m_done = 0; q.delete();
    for (int trial = 0; trial < 40; trial++) begin
      for (int k = 0; k < DEPTH; k++)
        cfg_write(3'(k), 8'($urandom), 8'($urandom_range(0, 3)));
      len = (trial == 0) ? 4'd12 : (trial == 1) ? 4'd0 : 4'($urandom_range(1, 15));
      bus.seq_len = len; bus.loop_en = 0;
      model_step(1, 0, 0, 0, len);
      drive(1, 0, 0, 0);
      check($sformatf("rand%0d_start", trial), outs(), model_exp());
      for (int c = 0; c < 300; c++) begin
        if (!m_act && !m_done) break;
        t  = ($urandom_range(0, 1) != 0);
        p  = bus.pause ? ($urandom_range(0, 1) != 0) : ($urandom_range(0, 7) == 0);
        st = (c == 299) || ($urandom_range(0, 99) == 0);
        s  = ($urandom_range(0, 19) == 0);
        model_step(s, t, p, st, len);
        drive(s, t, p, st);
        check($sformatf("rand%0d_c%0d", trial, c), outs(), model_exp());
      end
      bus.pause = 0;
      if (m_act || m_done) begin
        model_step(0, 0, 0, 1, len);
        drive(0, 0, 0, 1);
        check($sformatf("rand%0d_flush", trial), outs(), model_exp());
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
